// File: rtl/node_beta.sv
// Frame accumulator for node_alpha's unthrottled sample stream: a small FIFO
// absorbs samples, every FRAME_LEN of them are summed and offered on a valid/ready port.
module node_beta #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 4,
  parameter  int FRAME_LEN = 4,
  localparam int SUM_W     = WIDTH + $clog2(FRAME_LEN),
  localparam int FILL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              valid_in,
  input  logic              clear,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [FILL_W-1:0] fill_level,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [0:0]       state;

  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [SUM_W-1:0] acc_next;

  // A full FIFO still accepts a sample when the same edge frees a slot.
  assign full     = (fill_level == FULL_LVL);
  assign pop      = (state == ACCUM) && (fill_level != '0);
  assign push     = valid_in && (!full || pop);
  assign drop     = valid_in && !push;
  assign acc_next = acc + SUM_W'(mem[rd_ptr]);

  // Pointers are cleared on rst/clear, so stray writes on those edges are harmless.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      acc        <= '0;
      count      <= '0;
      state      <= ACCUM;
      sum_out    <= '0;
      sum_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !pop)
        fill_level <= fill_level + FILL_W'(1);
      else if (pop && !push)
        fill_level <= fill_level - FILL_W'(1);

      if (drop)
        overflow <= 1'b1;

      case (state)
        ACCUM: begin
          if (pop) begin
            acc   <= acc_next;
            count <= count + CNT_W'(1);
            if (count == LAST_CNT) begin
              sum_out   <= acc_next;
              sum_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          // The handshake edge only returns to ACCUM; popping resumes next edge.
          if (sum_ready) begin
            sum_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_node_beta.sv
// Scoreboard bench for node_beta: expected frame sums are queued as samples are
// driven and compared whenever the output handshake completes.
module tb_node_beta;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       clear;
  logic [9:0] sum_out;
  logic       sum_valid;
  logic       sum_ready;
  logic [2:0] fill_level;
  logic       overflow;

  int check_count = 0;
  int pass_count  = 0;
  int exp_q[$];

  node_beta #(.WIDTH(8), .DEPTH(4), .FRAME_LEN(4)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .valid_in(valid_in),
    .clear(clear),
    .sum_out(sum_out),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready),
    .fill_level(fill_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    check_count++;
    if (got == exp)
      pass_count++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample (or an idle cycle) for exactly one edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic drainScoreboard(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++)
      tick();
    checkOutput("drain", exp_q.size(), 0);
  endtask

  // Inputs only move at posedge+1, so a handshake seen here happens on the next edge.
  always @(negedge clk) begin
    if (!rst && sum_valid && sum_ready) begin
      if (exp_q.size() == 0)
        checkOutput("unexpected_sum", int'(sum_valid), 0);
      else
        checkOutput("sum", int'(sum_out), exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    valid_in  = 1'b1;
    data_in   = 8'hAA;
    sum_ready = 1'b1;

    // Reset with traffic present
    repeat (2) tick();
    checkOutput("rst_sum_valid", int'(sum_valid), 0);
    checkOutput("rst_sum_out", int'(sum_out), 0);
    checkOutput("rst_fill", int'(fill_level), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    rst      = 1'b0;
    valid_in = 1'b0;
    repeat (3) tick();
    checkOutput("idle_sum_valid", int'(sum_valid), 0);
    checkOutput("idle_fill", int'(fill_level), 0);

    // Basic frame with latency and single-cycle valid
    exp_q.push_back(10'h0A0);
    applyStimulus(1'b1, 8'h10);
    applyStimulus(1'b1, 8'h20);
    applyStimulus(1'b1, 8'h30);
    applyStimulus(1'b1, 8'h40);
    checkOutput("basic_fill_e3", int'(fill_level), 1);
    checkOutput("basic_early_valid", int'(sum_valid), 0);
    tick();
    checkOutput("basic_valid", int'(sum_valid), 1);
    checkOutput("basic_sum_out", int'(sum_out), 10'h0A0);
    checkOutput("basic_fill_end", int'(fill_level), 0);
    tick();
    checkOutput("basic_valid_one_cycle", int'(sum_valid), 0);
    drainScoreboard(5);

    // Maximum samples with gaps
    exp_q.push_back(10'h3FC);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hFF);
      applyStimulus(1'b0, 8'h00);
      applyStimulus(1'b0, 8'h00);
    end
    drainScoreboard(20);
    tick();
    checkOutput("hold_last_sum", int'(sum_out), 10'h3FC);
    checkOutput("hold_last_valid", int'(sum_valid), 0);

    // Stall: nine samples, the ninth is dropped
    sum_ready = 1'b0;
    exp_q.push_back(10'h004);
    exp_q.push_back(10'h004);
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 8'h01);
    checkOutput("stall_fill", int'(fill_level), 4);
    checkOutput("stall_overflow", int'(overflow), 1);
    checkOutput("stall_valid", int'(sum_valid), 1);
    checkOutput("stall_sum", int'(sum_out), 10'h004);
    repeat (3) tick();
    checkOutput("stall_valid_held", int'(sum_valid), 1);
    checkOutput("stall_sum_held", int'(sum_out), 10'h004);

    // Handshake, then push into a full FIFO on the first ACCUM edge
    sum_ready = 1'b1;
    tick();
    checkOutput("hs_valid_low", int'(sum_valid), 0);
    checkOutput("hs_fill_no_pop", int'(fill_level), 4);
    exp_q.push_back(10'h00B);
    applyStimulus(1'b1, 8'h05);
    checkOutput("fullpp_fill", int'(fill_level), 4);
    checkOutput("fullpp_overflow", int'(overflow), 1);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h03);
    checkOutput("fullpp_fill_after", int'(fill_level), 4);
    drainScoreboard(30);
    checkOutput("overflow_sticky", int'(overflow), 1);

    // Clear mid-frame discards the partial sum and the sample presented with it
    applyStimulus(1'b1, 8'h07);
    applyStimulus(1'b1, 8'h07);
    clear = 1'b1;
    applyStimulus(1'b1, 8'h07);
    clear = 1'b0;
    checkOutput("clear_fill", int'(fill_level), 0);
    checkOutput("clear_overflow", int'(overflow), 0);
    checkOutput("clear_valid", int'(sum_valid), 0);
    exp_q.push_back(10'h004);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'h01);
    drainScoreboard(20);

    // Reset mid-frame behaves like clear
    applyStimulus(1'b1, 8'h09);
    applyStimulus(1'b1, 8'h09);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h09);
    rst = 1'b0;
    checkOutput("midrst_fill", int'(fill_level), 0);
    checkOutput("midrst_sum_out", int'(sum_out), 0);
    exp_q.push_back(10'h008);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'h02);
    drainScoreboard(20);
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
